// File: rtl/clksel_cfg_tx_if.sv
// Clock-select configuration bus for clksel_cfg_tx.
// Carries three val/rdy channels:
//   cfg_*          host -> transmitter, msg = {accum_sel, mul_sel}
//   mul_clksel_*   transmitter -> MAC mul clock-select port
//   accum_clksel_* transmitter -> MAC accum clock-select port
// Modports:
//   master : the transmitter (accepts cfg, drives both clock selects)
//   slave  : the environment (host config source plus the MAC ports)
interface clksel_cfg_tx_if;
    logic       cfg_val;
    logic       cfg_rdy;
    logic [1:0] cfg_msg;
    logic       mul_clksel_val;
    logic       mul_clksel_rdy;
    logic       mul_clksel_msg;
    logic       accum_clksel_val;
    logic       accum_clksel_rdy;
    logic       accum_clksel_msg;

    modport master (
        input  cfg_val, cfg_msg, mul_clksel_rdy, accum_clksel_rdy,
        output cfg_rdy, mul_clksel_val, mul_clksel_msg,
               accum_clksel_val, accum_clksel_msg
    );

    modport slave (
        output cfg_val, cfg_msg, mul_clksel_rdy, accum_clksel_rdy,
        input  cfg_rdy, mul_clksel_val, mul_clksel_msg,
               accum_clksel_val, accum_clksel_msg
    );
endinterface

// File: rtl/clksel_cfg_tx.sv
// Clock-select configuration transmitter for the rational-GALS MAC.
// Holds the clock generators in reset for p_clk_reset_cycles after reset_n
// releases, then accepts a {accum_sel, mul_sel} configuration, delivers each
// select over its own val/rdy port, keeps the MAC domain in reset for
// p_settle_cycles after both selects land, and finally releases the domain.
// Ports:
//   clk, reset_n   single clock, asynchronous active-low reset
//   bus            clksel_cfg_tx_if.master (cfg, mul_clksel, accum_clksel)
//   clk_reset_out  active-high clock-generator reset (registered)
//   dom_reset_out  active-high MAC domain reset (registered)
//   done           high while the configuration is live (decoded from state)
module clksel_cfg_tx #(
    parameter int unsigned p_clk_reset_cycles = 2,
    parameter int unsigned p_settle_cycles    = 10
) (
    input  logic                   clk,
    input  logic                   reset_n,
    clksel_cfg_tx_if.master        bus,
    output logic                   clk_reset_out,
    output logic                   dom_reset_out,
    output logic                   done
);

    localparam int unsigned CNT_MAX = (p_clk_reset_cycles > p_settle_cycles) ?
                                      p_clk_reset_cycles : p_settle_cycles;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CLKRST_LAST = CNT_W'(p_clk_reset_cycles - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(p_settle_cycles);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(1);

    typedef enum logic [2:0] {
        CLKRST,
        IDLE,
        SEND,
        SETTLE,
        RUN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             mul_val;
    logic             mul_msg;
    logic             accum_val;
    logic             accum_msg;
    logic             mul_fire;
    logic             accum_fire;

    assign mul_fire   = mul_val   & bus.mul_clksel_rdy;
    assign accum_fire = accum_val & bus.accum_clksel_rdy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= CLKRST;
            cnt           <= '0;
            clk_reset_out <= 1'b1;
            dom_reset_out <= 1'b1;
            mul_val       <= 1'b0;
            mul_msg       <= 1'b0;
            accum_val     <= 1'b0;
            accum_msg     <= 1'b0;
        end else begin
            case (state)
                CLKRST: begin
                    if (cnt == CLKRST_LAST) begin
                        state         <= IDLE;
                        clk_reset_out <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE, RUN: begin
                    // cfg_rdy is high in both states, so cfg_val alone is the accept.
                    if (bus.cfg_val) begin
                        mul_msg       <= bus.cfg_msg[0];
                        accum_msg     <= bus.cfg_msg[1];
                        mul_val       <= 1'b1;
                        accum_val     <= 1'b1;
                        dom_reset_out <= 1'b1;
                        state         <= SEND;
                    end
                end
                SEND: begin
                    if (mul_fire)   mul_val   <= 1'b0;
                    if (accum_fire) accum_val <= 1'b0;
                    // A port is finished once its val is down or it fires this edge.
                    if ((!mul_val || mul_fire) && (!accum_val || accum_fire)) begin
                        state <= SETTLE;
                        cnt   <= SETTLE_LOAD;
                    end
                end
                SETTLE: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == SETTLE_LAST) begin
                        state         <= RUN;
                        dom_reset_out <= 1'b0;
                    end
                end
                default: begin
                    state         <= CLKRST;
                    cnt           <= '0;
                    clk_reset_out <= 1'b1;
                    dom_reset_out <= 1'b1;
                    mul_val       <= 1'b0;
                    accum_val     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cfg_rdy          = (state == IDLE) || (state == RUN);
    assign done                 = (state == RUN);
    assign bus.mul_clksel_val   = mul_val;
    assign bus.mul_clksel_msg   = mul_msg;
    assign bus.accum_clksel_val = accum_val;
    assign bus.accum_clksel_msg = accum_msg;

endmodule

// File: tb/tb_clksel_cfg_tx.sv
// Self-checking bench for clksel_cfg_tx. Inputs change and outputs are
// sampled 1 time unit after each rising edge; a negedge monitor scores each
// clock-select handshake against messages queued when a config is accepted.
module tb_clksel_cfg_tx;

    localparam int unsigned CLK_RST = 2;
    localparam int unsigned SETTLE  = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clk_reset_out;
    logic dom_reset_out;
    logic done;

    int checks = 0;
    int errors = 0;

    logic mul_q[$];
    logic acc_q[$];
    logic exp_m;
    logic exp_a;

    clksel_cfg_tx_if bus ();

    clksel_cfg_tx #(
        .p_clk_reset_cycles(CLK_RST),
        .p_settle_cycles   (SETTLE)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .clk_reset_out(clk_reset_out),
        .dom_reset_out(dom_reset_out),
        .done         (done)
    );

    always #5 clk = ~clk;

    task tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake scoreboard: val&rdy seen at negedge completes on the next posedge.
    always @(negedge clk) begin
        if (reset_n && bus.mul_clksel_val && bus.mul_clksel_rdy) begin
            checks++;
            if (mul_q.size() == 0) begin
                errors++;
                $display("FAIL mul_hs_unexpected got msg=%0b, no config pending", bus.mul_clksel_msg);
            end else begin
                exp_m = mul_q.pop_front();
                if (bus.mul_clksel_msg !== exp_m) begin
                    errors++;
                    $display("FAIL mul_hs_msg got %0b expected %0b", bus.mul_clksel_msg, exp_m);
                end
            end
        end
        if (reset_n && bus.accum_clksel_val && bus.accum_clksel_rdy) begin
            checks++;
            if (acc_q.size() == 0) begin
                errors++;
                $display("FAIL acc_hs_unexpected got msg=%0b, no config pending", bus.accum_clksel_msg);
            end else begin
                exp_a = acc_q.pop_front();
                if (bus.accum_clksel_msg !== exp_a) begin
                    errors++;
                    $display("FAIL acc_hs_msg got %0b expected %0b", bus.accum_clksel_msg, exp_a);
                end
            end
        end
    end

    // Releases reset and walks CLKRST into IDLE.
    task powerup_seq();
        logic [4:0] got, exp;
        tick();
        reset_n = 1'b1;
        for (int i = 1; i <= int'(CLK_RST) + 1; i++) begin
            tick();
            got = {clk_reset_out, bus.cfg_rdy, dom_reset_out, bus.mul_clksel_val, bus.accum_clksel_val};
            exp = {(i < int'(CLK_RST)), (i >= int'(CLK_RST)), 1'b1, 1'b0, 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL powerup_edge%0d {clkrst,cfg_rdy,domrst,mval,aval} got %b expected %b", i, got, exp);
            end
        end
    endtask

    task check_reset_values(input string tag);
        logic [7:0] got;
        got = {clk_reset_out, dom_reset_out, bus.cfg_rdy, bus.mul_clksel_val,
               bus.accum_clksel_val, bus.mul_clksel_msg, bus.accum_clksel_msg, done};
        checks++;
        if (got !== 8'b1100_0000) begin
            errors++;
            $display("FAIL %s {clkrst,domrst,cfg_rdy,mval,aval,mmsg,amsg,done} got %b expected 11000000", tag, got);
        end
    endtask

    task accept(input logic [1:0] m);
        logic [5:0] got, exp;
        checks++;
        if (bus.cfg_rdy !== 1'b1) begin
            errors++;
            $display("FAIL accept_cfg_rdy got %b expected 1", bus.cfg_rdy);
        end
        bus.cfg_val = 1'b1;
        bus.cfg_msg = m;
        mul_q.push_back(m[0]);
        acc_q.push_back(m[1]);
        tick();
        bus.cfg_val = 1'b0;
        got = {bus.mul_clksel_val, bus.accum_clksel_val, bus.mul_clksel_msg,
               bus.accum_clksel_msg, dom_reset_out, done};
        exp = {1'b1, 1'b1, m[0], m[1], 1'b1, 1'b0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL accept_%b {mval,aval,mmsg,amsg,domrst,done} got %b expected %b", m, got, exp);
        end
    endtask

    task test_reset();
        bus.cfg_val = 1'b0;
        bus.cfg_msg = 2'b00;
        bus.mul_clksel_rdy = 1'b0;
        bus.accum_clksel_rdy = 1'b0;
        reset_n = 1'b0;
        #1;
        repeat (2) tick();
        check_reset_values("reset_state");
        powerup_seq();
    endtask

    task test_basic();
        logic [4:0] got, exp;
        bus.mul_clksel_rdy = 1'b1;
        bus.accum_clksel_rdy = 1'b1;
        accept(2'b10);
        for (int i = 1; i <= int'(SETTLE) + 1; i++) begin
            tick();
            got = {bus.mul_clksel_val, bus.accum_clksel_val, dom_reset_out, done, bus.cfg_rdy};
            exp = {1'b0, 1'b0, (i <= int'(SETTLE)), (i > int'(SETTLE)), (i > int'(SETTLE))};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL basic_edge%0d {mval,aval,domrst,done,cfg_rdy} got %b expected %b", i, got, exp);
            end
        end
    endtask

    task test_skewed();
        logic [3:0] got, exp;
        bus.mul_clksel_rdy = 1'b0;
        bus.accum_clksel_rdy = 1'b0;
        accept(2'b11);
        for (int i = 1; i <= 15; i++) begin
            bus.mul_clksel_rdy = (i == 1);
            bus.accum_clksel_rdy = (i == 5);
            tick();
            got = {bus.mul_clksel_val, bus.accum_clksel_val, dom_reset_out, done};
            exp = {1'b0, (i < 5), (i < 15), (i >= 15)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL skewed_edge%0d {mval,aval,domrst,done} got %b expected %b", i, got, exp);
            end
        end
        bus.mul_clksel_rdy = 1'b0;
        bus.accum_clksel_rdy = 1'b0;
    endtask

    task test_reconfig();
        logic [3:0] got, exp;
        bus.mul_clksel_rdy = 1'b1;
        bus.accum_clksel_rdy = 1'b1;
        accept(2'b01);
        for (int i = 1; i <= int'(SETTLE) + 1; i++) begin
            tick();
            got = {bus.mul_clksel_msg, bus.accum_clksel_msg, dom_reset_out, done};
            exp = {1'b1, 1'b0, (i <= int'(SETTLE)), (i > int'(SETTLE))};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reconfig_edge%0d {mmsg,amsg,domrst,done} got %b expected %b", i, got, exp);
            end
        end
    endtask

    task test_ignored();
        logic [5:0] got, exp;
        bus.mul_clksel_rdy = 1'b1;
        bus.accum_clksel_rdy = 1'b1;
        accept(2'b10);
        for (int i = 1; i <= int'(SETTLE) + 3; i++) begin
            bus.cfg_val = (i <= int'(SETTLE));
            bus.cfg_msg = 2'b01;
            tick();
            got = {bus.mul_clksel_msg, bus.accum_clksel_msg, bus.mul_clksel_val,
                   bus.accum_clksel_val, done, bus.cfg_rdy};
            exp = {1'b0, 1'b1, 1'b0, 1'b0, (i > int'(SETTLE)), (i > int'(SETTLE))};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL ignored_edge%0d {mmsg,amsg,mval,aval,done,cfg_rdy} got %b expected %b", i, got, exp);
            end
        end
        bus.cfg_val = 1'b0;
    endtask

    task test_mid_reset();
        logic [2:0] got;
        // Reset in the middle of SETTLE.
        bus.mul_clksel_rdy = 1'b1;
        bus.accum_clksel_rdy = 1'b1;
        accept(2'b11);
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        check_reset_values("reset_mid_settle");
        powerup_seq();
        // Reset in the middle of SEND with handshakes still pending.
        bus.mul_clksel_rdy = 1'b0;
        bus.accum_clksel_rdy = 1'b0;
        accept(2'b01);
        reset_n = 1'b0;
        #1;
        check_reset_values("reset_mid_send");
        mul_q.delete();
        acc_q.delete();
        tick();
        powerup_seq();
        // Sequence works again after recovery.
        bus.mul_clksel_rdy = 1'b1;
        bus.accum_clksel_rdy = 1'b1;
        accept(2'b10);
        repeat (SETTLE + 1) tick();
        got = {dom_reset_out, done, bus.accum_clksel_msg};
        checks++;
        if (got !== 3'b011) begin
            errors++;
            $display("FAIL post_reset_run {domrst,done,amsg} got %b expected 011", got);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_skewed();
        test_reconfig();
        test_ignored();
        test_mid_reset();
        tick();
        checks++;
        if (mul_q.size() != 0 || acc_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending mul=%0d acc=%0d expected 0 0", mul_q.size(), acc_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
